// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature counter: decode-mode encodings and
// the legal ranges of the block parameters.
package quad_pkg;

  typedef enum logic [1:0] {
    MODE_X1  = 2'd0,
    MODE_X2  = 2'd1,
    MODE_X4  = 2'd2,
    MODE_OFF = 2'd3
  } mode_e;

  localparam int CNT_W_MIN    = 4;
  localparam int CNT_W_MAX    = 32;
  localparam int FILT_LEN_MIN = 1;
  localparam int FILT_LEN_MAX = 15;
  localparam int STAB_W       = 4;

endpackage : quad_pkg

// File: rtl/quad_filter.sv
// Two-flop synchroniser followed by a stability filter: the output level moves
// only after FILT_LEN consecutive synchronised samples disagree with it.
module quad_filter
  import quad_pkg::*;
#(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic dout_o
);

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(FILT_LEN - 1);

  logic              sync1_q;
  logic              sync2_q;
  logic              level_q;
  logic              level_d;
  logic [STAB_W-1:0] stab_q;
  logic [STAB_W-1:0] stab_d;

  // Any sample that agrees with the held level restarts the window.
  always_comb begin
    level_d = level_q;
    stab_d  = '0;
    if (sync2_q != level_q) begin
      if (stab_q == STAB_LAST) begin
        level_d = sync2_q;
      end else begin
        stab_d = stab_q + STAB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      stab_q  <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      stab_q  <= stab_d;
    end
  end

  assign dout_o = level_q;

endmodule : quad_filter

// File: rtl/quad_counter.sv
// Quadrature encoder counter: filtered A/B/index inputs, X1/X2/X4 decode,
// wrap or saturate counting, clear-on-index, snapshot capture and error flag.
module quad_counter
  import quad_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             quadA,
  input  logic             quadB,
  input  logic             index,
  input  logic [1:0]       mode,
  input  logic             idx_clr_en,
  input  logic             clr,
  input  logic             latch,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] snapshot,
  output logic             dir,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};

  logic a_f;
  logic b_f;
  logic idx_f;

  quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk(clk), .rst_n(rst_n), .din_i(quadA), .dout_o(a_f)
  );
  quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk(clk), .rst_n(rst_n), .din_i(quadB), .dout_o(b_f)
  );
  quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_idx (
    .clk(clk), .rst_n(rst_n), .din_i(index), .dout_o(idx_f)
  );

  logic [1:0]       ab_prev_q;
  logic             idx_prev_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] snap_q;
  logic [CNT_W-1:0] snap_d;
  logic             dir_q;
  logic             dir_d;
  logic             err_q;
  logic             err_d;

  logic a_chg;
  logic b_chg;
  logic illegal;
  logic step_req;
  logic step_up;
  logic idx_clear;

  always_comb begin
    a_chg     = a_f ^ ab_prev_q[1];
    b_chg     = b_f ^ ab_prev_q[0];
    illegal   = a_chg & b_chg;
    step_up   = a_f ^ ab_prev_q[0];
    idx_clear = idx_clr_en & idx_f & ~idx_prev_q;

    step_req = 1'b0;
    unique case (mode_e'(mode))
      MODE_X4:  step_req = a_chg ^ b_chg;
      MODE_X2:  step_req = a_chg & ~b_chg;
      MODE_X1:  step_req = a_chg & ~b_chg & a_f;
      MODE_OFF: step_req = 1'b0;
      default:  step_req = 1'b0;
    endcase

    count_d = count_q;
    dir_d   = dir_q;
    // clr beats an index clear, which in turn swallows any coincident step.
    if (clr || idx_clear) begin
      count_d = '0;
    end else if (step_req) begin
      dir_d = step_up;
      if (step_up) begin
        if (!(SATURATE && count_q == CNT_MAX)) count_d = count_q + CNT_ONE;
      end else begin
        if (!(SATURATE && count_q == CNT_MIN)) count_d = count_q - CNT_ONE;
      end
    end

    snap_d = snap_q;
    if (latch || idx_clear) snap_d = count_q;

    err_d = err_q;
    if (illegal)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ab_prev_q  <= 2'b00;
      idx_prev_q <= 1'b0;
      count_q    <= '0;
      snap_q     <= '0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ab_prev_q  <= {a_f, b_f};
      idx_prev_q <= idx_f;
      count_q    <= count_d;
      snap_q     <= snap_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
    end
  end

  assign count    = count_q;
  assign snapshot = snap_q;
  assign dir      = dir_q;
  assign err      = err_q;

endmodule : quad_counter

// File: tb/tb_quad_counter.sv
// Directed bench for quad_counter: a 16-bit wrapping instance plus two 4-bit
// instances (wrap and saturate) share the same pin stimulus.
module tb_quad_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       quadA = 1'b0, quadB = 1'b0, index = 1'b0;
  logic [1:0] mode = 2'd2;
  logic       idx_clr_en = 1'b0, clr = 1'b0, latch = 1'b0, err_clr = 1'b0;

  logic [15:0] count, snapshot;
  logic        dir, err;
  logic [3:0]  w_count, w_snap, s_count, s_snap;
  logic        w_dir, w_err, s_dir, s_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  quad_counter #(.CNT_W(16), .FILT_LEN(3), .SATURATE(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .quadA(quadA), .quadB(quadB), .index(index),
    .mode(mode), .idx_clr_en(idx_clr_en), .clr(clr), .latch(latch),
    .err_clr(err_clr), .count(count), .snapshot(snapshot), .dir(dir), .err(err)
  );

  quad_counter #(.CNT_W(4), .FILT_LEN(3), .SATURATE(1'b0)) u_w4_wrap (
    .clk(clk), .rst_n(rst_n), .quadA(quadA), .quadB(quadB), .index(index),
    .mode(mode), .idx_clr_en(idx_clr_en), .clr(clr), .latch(latch),
    .err_clr(err_clr), .count(w_count), .snapshot(w_snap), .dir(w_dir), .err(w_err)
  );

  quad_counter #(.CNT_W(4), .FILT_LEN(3), .SATURATE(1'b1)) u_w4_sat (
    .clk(clk), .rst_n(rst_n), .quadA(quadA), .quadB(quadB), .index(index),
    .mode(mode), .idx_clr_en(idx_clr_en), .clr(clr), .latch(latch),
    .err_clr(err_clr), .count(s_count), .snapshot(s_snap), .dir(s_dir), .err(s_err)
  );

  // Forward quadrature order on {A,B}: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] fwd_next(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev_next(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {quadA, quadB, index} = 3'b000;
    {idx_clr_en, clr, latch, err_clr} = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic hold_ab(input logic [1:0] ab, input int cycles);
    {quadA, quadB} = ab;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({count, snapshot, dir, err} !== 34'd0) begin
      $display("FAIL reset_state: got count=%h snap=%h dir=%b err=%b, want all 0",
               count, snapshot, dir, err);
      miscompares++;
    end
  endtask

  task automatic test_x4_forward();
    logic [1:0] ab;
    do_reset();
    mode = 2'd2;
    ab = 2'b10;
    {quadA, quadB} = ab;
    repeat (5) @(negedge clk);
    vectors++;
    if (count !== 16'd0) begin
      $display("FAIL x4_latency_early: count=%h want 0000 after 5 cycles", count);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (count !== 16'd1) begin
      $display("FAIL x4_latency_step: count=%h want 0001 after 6 cycles", count);
      miscompares++;
    end
    repeat (4) @(negedge clk);
    for (int i = 1; i < 8; i++) begin
      ab = fwd_next(ab);
      hold_ab(ab, 10);
    end
    vectors++;
    if (count !== 16'd8 || dir !== 1'b1) begin
      $display("FAIL x4_forward: count=%h dir=%b want 0008 dir=1", count, dir);
      miscompares++;
    end
  endtask

  task automatic test_x1_x2_reverse();
    logic [1:0] ab;
    do_reset();
    mode = 2'd0;
    ab = 2'b00;
    for (int i = 0; i < 16; i++) begin
      ab = rev_next(ab);
      hold_ab(ab, 10);
    end
    vectors++;
    if (count !== 16'hFFFC) begin
      $display("FAIL x1_reverse: count=%h want fffc", count);
      miscompares++;
    end
    mode = 2'd1;
    for (int i = 0; i < 16; i++) begin
      ab = rev_next(ab);
      hold_ab(ab, 10);
    end
    vectors++;
    if (count !== 16'hFFF4 || dir !== 1'b0) begin
      $display("FAIL x2_reverse: count=%h dir=%b want fff4 dir=0", count, dir);
      miscompares++;
    end
  endtask

  task automatic test_glitch_and_err();
    do_reset();
    mode = 2'd2;
    quadA = 1'b1;
    repeat (2) @(negedge clk);
    quadA = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (count !== 16'd0 || err !== 1'b0) begin
      $display("FAIL glitch_reject: count=%h err=%b want 0000 err=0", count, err);
      miscompares++;
    end
    hold_ab(2'b11, 10);
    vectors++;
    if (count !== 16'd0 || err !== 1'b1) begin
      $display("FAIL double_change: count=%h err=%b want 0000 err=1", count, err);
      miscompares++;
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    vectors++;
    if (err !== 1'b0) begin
      $display("FAIL err_clr: err=%b want 0", err);
      miscompares++;
    end
    // err_clr lands on the same cycle as a fresh double change.
    {quadA, quadB} = 2'b00;
    repeat (5) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    vectors++;
    if (err !== 1'b1 || count !== 16'd0) begin
      $display("FAIL err_set_wins: err=%b count=%h want err=1 count=0000", err, count);
      miscompares++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mode_off();
    do_reset();
    mode = 2'd2;
    hold_ab(2'b10, 10);
    hold_ab(2'b11, 10);
    mode = 2'd3;
    @(negedge clk);
    vectors++;
    if (count !== 16'd2) begin
      $display("FAIL mode_change_hold: count=%h want 0002", count);
      miscompares++;
    end
    hold_ab(2'b10, 10);
    vectors++;
    if (count !== 16'd2 || dir !== 1'b1) begin
      $display("FAIL mode_off_hold: count=%h dir=%b want 0002 dir=1", count, dir);
      miscompares++;
    end
    hold_ab(2'b01, 10);
    vectors++;
    if (err !== 1'b1 || count !== 16'd2) begin
      $display("FAIL mode_off_err: err=%b count=%h want err=1 count=0002", err, count);
      miscompares++;
    end
  endtask

  task automatic test_saturate();
    logic [1:0] ab;
    do_reset();
    mode = 2'd2;
    ab = 2'b00;
    for (int i = 0; i < 9; i++) begin
      ab = fwd_next(ab);
      hold_ab(ab, 10);
    end
    vectors++;
    if (w_count !== 4'h9 || s_count !== 4'h7 || s_dir !== 1'b1 || count !== 16'd9) begin
      $display("FAIL up_9_steps: wrap=%h sat=%h sat_dir=%b main=%h want 9 7 1 0009",
               w_count, s_count, s_dir, count);
      miscompares++;
    end
    for (int i = 0; i < 16; i++) begin
      ab = rev_next(ab);
      hold_ab(ab, 8);
    end
    vectors++;
    if (w_count !== 4'h9 || s_count !== 4'h8 || s_dir !== 1'b0 || count !== 16'hFFF9) begin
      $display("FAIL down_16_steps: wrap=%h sat=%h sat_dir=%b main=%h want 9 8 0 fff9",
               w_count, s_count, s_dir, count);
      miscompares++;
    end
  endtask

  task automatic test_index_latch_clr();
    logic [1:0] ab;
    do_reset();
    mode = 2'd2;
    ab = 2'b00;
    for (int i = 0; i < 25; i++) begin
      ab = fwd_next(ab);
      hold_ab(ab, 8);
    end
    vectors++;
    if (count !== 16'd25) begin
      $display("FAIL pre_index_count: count=%h want 0019", count);
      miscompares++;
    end
    idx_clr_en = 1'b1;
    ab = rev_next(ab);
    {quadA, quadB} = ab;
    index = 1'b1;
    repeat (5) @(negedge clk);
    latch = 1'b1;
    @(negedge clk);
    latch = 1'b0;
    vectors++;
    if (snapshot !== 16'd25 || count !== 16'd0) begin
      $display("FAIL index_clear: snap=%h count=%h want 0019 0000", snapshot, count);
      miscompares++;
    end
    repeat (4) @(negedge clk);
    index = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      ab = fwd_next(ab);
      hold_ab(ab, 10);
    end
    latch = 1'b1;
    @(negedge clk);
    latch = 1'b0;
    vectors++;
    if (snapshot !== 16'd3 || count !== 16'd3) begin
      $display("FAIL latch_only: snap=%h count=%h want 0003 0003", snapshot, count);
      miscompares++;
    end
    ab = fwd_next(ab);
    hold_ab(ab, 10);
    clr = 1'b1;
    latch = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    latch = 1'b0;
    vectors++;
    if (snapshot !== 16'd4 || count !== 16'd0) begin
      $display("FAIL clr_with_latch: snap=%h count=%h want 0004 0000", snapshot, count);
      miscompares++;
    end
    ab = fwd_next(ab);
    {quadA, quadB} = ab;
    repeat (5) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (count !== 16'd0) begin
      $display("FAIL clr_over_step: count=%h want 0000", count);
      miscompares++;
    end
    idx_clr_en = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [1:0] ab;
    do_reset();
    mode = 2'd2;
    ab = 2'b11;
    hold_ab(ab, 10);
    for (int i = 0; i < 100; i++) begin
      ab = fwd_next(ab);
      hold_ab(ab, 8);
    end
    latch = 1'b1;
    @(negedge clk);
    latch = 1'b0;
    vectors++;
    if (count !== 16'd100 || err !== 1'b1 || snapshot !== 16'd100) begin
      $display("FAIL pre_reset: count=%h err=%b snap=%h want 0064 1 0064", count, err, snapshot);
      miscompares++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({count, snapshot, dir, err} !== 34'd0) begin
      $display("FAIL async_reset: count=%h snap=%h dir=%b err=%b want all 0",
               count, snapshot, dir, err);
      miscompares++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    {quadA, quadB} = 2'b00;
  endtask

  initial begin
    test_reset();
    test_x4_forward();
    test_x1_x2_reverse();
    test_glitch_and_err();
    test_mode_off();
    test_saturate();
    test_index_latch_clr();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_quad_counter

// File: doc/quad_counter.md
QUAD_COUNTER -- requirements
Module: quad_counter

Interface
REQ-001 Parameter CNT_W, default 16: count register width in bits, legal range 4..32.
REQ-002 Parameter FILT_LEN, default 3: consecutive equal synchronised samples required to accept a new level, legal range 1..15.
REQ-003 Parameter SATURATE, default 0: 0 means the count wraps, 1 means the count clamps at its limits.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 quadA, quadB  input  1 each  raw encoder phases, asynchronous to clk.
REQ-007 index  input  1  raw encoder index pulse, asynchronous to clk.
REQ-008 mode  input  2  decode mode: 0 = X1, 1 = X2, 2 = X4, 3 = counting disabled.
REQ-009 idx_clr_en  input  1  enables clear-on-index.
REQ-010 clr  input  1  synchronous clear of count, single cycle.
REQ-011 latch  input  1  capture strobe for snapshot, single cycle.
REQ-012 count  output  CNT_W  live position count, two's complement.
REQ-013 snapshot  output  CNT_W  count captured by latch or by index.
REQ-014 dir  output  1  direction of the last accepted step: 1 = up, 0 = down.
REQ-015 err  output  1  sticky illegal-transition flag.
REQ-016 err_clr  input  1  clears err.

Function
REQ-017 Each of quadA, quadB and index SHALL pass through a 2-flop synchroniser, then a filter; the filtered level changes only after FILT_LEN consecutive synchronised samples differ from it.
REQ-018 The filter's stability counter SHALL restart whenever the synchronised sample toggles before acceptance.
REQ-019 Latency from a stable pin change to the count update SHALL be exactly FILT_LEN+3 clk cycles.
REQ-020 Decode SHALL compare the current filtered {A,B} against the previous filtered {A,B} each cycle.
REQ-021 The decoded step direction SHALL be up when A_new XOR B_old = 1, and down otherwise.
REQ-022 In X4 mode, every single-phase change SHALL step the count by 1.
REQ-023 In X2 mode, only A changes SHALL step the count.
REQ-024 In X1 mode, only A rising edges SHALL step the count, with the direction taken as in REQ-021.
REQ-025 In mode 3, the count SHALL hold, dir SHALL hold, and err detection SHALL remain active.
REQ-026 A cycle in which A and B both change SHALL NOT step the count and SHALL set err, in every mode.
REQ-027 Once set, err SHALL stay set until err_clr is asserted.
REQ-028 When err_clr and a new illegal transition occur in the same cycle, err SHALL remain 1.
REQ-029 dir SHALL update only on cycles where the count steps.
REQ-030 With SATURATE=0, the count SHALL wrap modulo 2^CNT_W in both directions.
REQ-031 With SATURATE=1, the count SHALL clamp at 2^(CNT_W-1)-1 upward and at -2^(CNT_W-1) downward.
REQ-032 With SATURATE=1, a clamped step SHALL still update dir.
REQ-033 An index rising edge (filtered) with idx_clr_en=1 SHALL load snapshot with the pre-clear count and set count to 0 on the same edge.
REQ-034 A step coinciding with that index edge SHALL be discarded.
REQ-035 clr SHALL set count to 0 on the next edge, overriding any step or index event that cycle.
REQ-036 latch SHALL load snapshot with the count value before the same-edge update.
REQ-037 When latch and an index clear occur in the same cycle, they capture the same value and snapshot SHALL take it.
REQ-038 When clr and latch occur in the same cycle, snapshot SHALL get the pre-clear count and count SHALL become 0.
REQ-039 A mode change SHALL take effect on the next cycle and SHALL NOT alter the count.

Reset
REQ-040 rst_n low SHALL asynchronously force count=0, snapshot=0, dir=0 and err=0.
REQ-041 rst_n low SHALL asynchronously clear all synchroniser flops, filter levels, stability counters and the previous {A,B} register to 0.
REQ-042 Reset deassertion SHALL be synchronised externally.
REQ-043 The first accepted filtered level after reset SHALL be treated as a transition from {0,0}: a single-phase change steps the count, a double change sets err.
REQ-044 Reset asserted mid-filter-window SHALL discard the partial window.

Structure
REQ-045 A shared package quad_pkg SHALL hold the mode encodings (X1, X2, X4, OFF) and the legal parameter limits.
REQ-046 One sub-module, quad_filter (synchroniser plus stability filter, FILT_LEN parameter), SHALL be instantiated three times.
REQ-047 Decode, counting and capture SHALL reside in quad_counter.

Verification
REQ-048 X4 mode, FILT_LEN=3: 8 forward quadrature states with each held 10 cycles -> count=8, dir=1, first step exactly 6 cycles after the pin change.
REQ-049 X1 mode then X2 mode, each given 4 full reverse cycles -> count=-4 after X1, then count=-12 after X2, dir=0.
REQ-050 A 2-cycle glitch on quadA with FILT_LEN=3 -> count unchanged; then {A,B} 00 to 11 in one step -> err=1 and count unchanged; then err_clr -> err=0.
REQ-051 CNT_W=4: SATURATE=0 with 9 up steps from 0 -> count=-7 (0x9); SATURATE=1 with the same stimulus -> count=7.
REQ-052 idx_clr_en=1, count=25, an index pulse coinciding with a step, plus latch in the same cycle -> snapshot=25, count=0.
REQ-053 rst_n dropped asynchronously mid-stream with count=100 and err=1 -> all outputs 0 immediately, with no clk edge required.
